// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_ctrl_if : E-stage <-> multiply/divide sequencer signal bundle      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface mdu_ctrl_if;
  logic [3:0]  MDUOp;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output MDUOp, start, A, B, input busy, HI, LO);
  modport slave  (input MDUOp, start, A, B, output busy, HI, LO);
endinterface
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_ctrl : multiply/divide sequencer owning HI/LO, busy-counter model  |
// | Optional: define MDU_MADD_EN to decode madd/maddu/msub/msubu (7-10)    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);
  localparam int c_MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MTHI  = 4'd5;
  localparam logic [3:0] c_OP_MTLO  = 4'd6;
  localparam logic [3:0] c_OP_MADD  = 4'd7;
  localparam logic [3:0] c_OP_MSUB  = 4'd9;

  logic [0:0]         r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]        r_hi, r_lo, r_phi, r_plo;
  logic [31:0]        w_hi_nxt, w_lo_nxt, w_phi_nxt, w_plo_nxt;
  logic               r_pwr, w_pwr_nxt;

  logic        w_accept, w_is_mul, w_is_div, w_mul_lat, w_signed;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_dvd, w_dvs, w_uq, w_ur, w_quo, w_rem;

  assign w_accept = bus.start && (r_state == c_ST_IDLE);
  assign w_is_mul = (bus.MDUOp == c_OP_MULT) || (bus.MDUOp == c_OP_MULTU);
  assign w_is_div = (bus.MDUOp == c_OP_DIV)  || (bus.MDUOp == c_OP_DIVU);
  assign w_signed = (bus.MDUOp == c_OP_MULT) || (bus.MDUOp == c_OP_DIV)
                 || (bus.MDUOp == c_OP_MADD) || (bus.MDUOp == c_OP_MSUB);

  // Low 64 bits of the extended product are correct for both signednesses.
  assign w_a_ext = w_signed ? {{32{bus.A[31]}}, bus.A} : {32'b0, bus.A};
  assign w_b_ext = w_signed ? {{32{bus.B[31]}}, bus.B} : {32'b0, bus.B};
  assign w_prod  = w_a_ext * w_b_ext;

  // Sign-magnitude divide keeps 0x80000000 / -1 well defined.
  assign w_a_neg = w_signed && bus.A[31];
  assign w_b_neg = w_signed && bus.B[31];
  assign w_dvd   = w_a_neg ? (32'd0 - bus.A) : bus.A;
  assign w_dvs   = (bus.B == 32'd0) ? 32'd1 : (w_b_neg ? (32'd0 - bus.B) : bus.B);
  assign w_uq    = w_dvd / w_dvs;
  assign w_ur    = w_dvd % w_dvs;
  assign w_quo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
  assign w_rem   = w_a_neg ? (32'd0 - w_ur) : w_ur;

`ifdef MDU_MADD_EN
  logic        w_is_acc, w_is_sub;
  logic [63:0] w_acc;
  assign w_is_acc  = (bus.MDUOp >= 4'd7) && (bus.MDUOp <= 4'd10);
  assign w_is_sub  = (bus.MDUOp == c_OP_MSUB) || (bus.MDUOp == 4'd10);
  assign w_acc     = w_is_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
  assign w_mul_lat = w_is_mul || w_is_acc;
`else
  assign w_mul_lat = w_is_mul;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_pwr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_phi   <= w_phi_nxt;
      r_plo   <= w_plo_nxt;
      r_pwr   <= w_pwr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept && w_mul_lat) begin
          w_cnt_nxt   = c_CNT_W'(MULT_CYC);
          w_state_nxt = c_ST_RUN;
        end else if (w_accept && w_is_div) begin
          w_cnt_nxt   = c_CNT_W'(DIV_CYC);
          w_state_nxt = c_ST_RUN;
        end
      end
      default: begin
        w_cnt_nxt = r_cnt - c_CNT_W'(1);
        if (r_cnt == c_CNT_W'(1)) w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    w_phi_nxt = r_phi;
    w_plo_nxt = r_plo;
    w_pwr_nxt = r_pwr;
    if (r_state == c_ST_IDLE) begin
      if (w_accept) begin
        if (bus.MDUOp == c_OP_MTHI) w_hi_nxt = bus.A;
        if (bus.MDUOp == c_OP_MTLO) w_lo_nxt = bus.A;
        if (w_is_mul) begin
          {w_phi_nxt, w_plo_nxt} = w_prod;
          w_pwr_nxt = 1'b1;
        end
`ifdef MDU_MADD_EN
        if (w_is_acc) begin
          {w_phi_nxt, w_plo_nxt} = w_acc;
          w_pwr_nxt = 1'b1;
        end
`endif
        if (w_is_div) begin
          w_phi_nxt = w_rem;
          w_plo_nxt = w_quo;
          w_pwr_nxt = (bus.B != 32'd0);
        end
      end
    end else if ((r_cnt == c_CNT_W'(1)) && r_pwr) begin
      w_hi_nxt = r_phi;
      w_lo_nxt = r_plo;
    end
  end

  assign bus.busy = (r_cnt != '0);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mdu_ctrl : directed self-checking bench for mdu_ctrl                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mdu_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one start cycle, then scrambles operands to prove they were captured.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.MDUOp = 4'd0;
    bus.A     = 32'hA5A5_5A5A;
    bus.B     = 32'h0000_0007;
  endtask

  // Called right after issue(): busy for n cycles, HI/LO held until commit.
  task automatic run_op(input string tag, input int n,
                        input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                        input logic [31:0] exp_hi,  input logic [31:0] exp_lo);
    check({tag, "_busy0"}, {31'b0, bus.busy}, 32'd1);
    for (int i = 1; i < n; i++) begin
      tick();
      check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
      check({tag, "_hold_hi"}, bus.HI, hold_hi);
      check({tag, "_hold_lo"}, bus.LO, hold_lo);
    end
    tick();
    check({tag, "_done_busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_hi"}, bus.HI, exp_hi);
    check({tag, "_lo"}, bus.LO, exp_lo);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b0;
    bus.MDUOp = 4'd0;
    bus.start = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    tick();
    tick();
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    reset = 1'b1;

    // Reset in the middle of a mult discards it
    issue(4'd1, 32'd3, 32'd4);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rstmid_busy", {31'b0, bus.busy}, 32'd0);
    check("rstmid_hi", bus.HI, 32'd0);
    check("rstmid_lo", bus.LO, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("rstmid_nocommit_busy", {31'b0, bus.busy}, 32'd0);
    check("rstmid_nocommit_lo", bus.LO, 32'd0);

    // mult / multu
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    run_op("mult", 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    run_op("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);

    // div / divu
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    run_op("div", 10, 32'h2, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4'd4, 32'd7, 32'd2);
    run_op("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_ovf", 10, 32'd1, 32'd3, 32'd0, 32'h8000_0000);

    // mthi/mtlo back-to-back
    issue(4'd5, 32'h1234, 32'd0);
    check("mthi_hi", bus.HI, 32'h1234);
    check("mthi_busy", {31'b0, bus.busy}, 32'd0);
    issue(4'd6, 32'h5678, 32'd0);
    check("mtlo_lo", bus.LO, 32'h5678);
    check("mtlo_hi", bus.HI, 32'h1234);
    check("mtlo_busy", {31'b0, bus.busy}, 32'd0);

    // Divide by zero leaves HI/LO untouched
    issue(4'd5, 32'h11, 32'd0);
    issue(4'd6, 32'h22, 32'd0);
    issue(4'd3, 32'd5, 32'd0);
    run_op("div0", 10, 32'h11, 32'h22, 32'h11, 32'h22);

    // mthi while busy is ignored
    issue(4'd1, 32'd3, 32'd4);
    issue(4'd5, 32'hDEAD, 32'd0);
    check("mthi_busy_hi", bus.HI, 32'h11);
    check("mthi_busy_busy", {31'b0, bus.busy}, 32'd1);
    tick();
    tick();
    tick();
    check("mthi_busy_run", {31'b0, bus.busy}, 32'd1);
    tick();
    check("mthi_busy_done", {31'b0, bus.busy}, 32'd0);
    check("mthi_busy_res_hi", bus.HI, 32'd0);
    check("mthi_busy_res_lo", bus.LO, 32'd12);

    // div with mult starts at cycle 3 and at the completing cycle
    issue(4'd3, 32'd100, 32'd7);
    tick();
    tick();
    issue(4'd1, 32'd9, 32'd9);
    check("ign3_lo", bus.LO, 32'd12);
    for (int i = 0; i < 6; i++) tick();
    check("ign_last_busy", {31'b0, bus.busy}, 32'd1);
    issue(4'd1, 32'd9, 32'd9);
    check("ign_commit_busy", {31'b0, bus.busy}, 32'd0);
    check("ign_commit_hi", bus.HI, 32'd2);
    check("ign_commit_lo", bus.LO, 32'd14);
    issue(4'd1, 32'd5, 32'd6);
    run_op("after_div", 5, 32'd2, 32'd14, 32'd0, 32'd30);

    // madd accumulate (or ignored without the option)
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    run_op("madd", 5, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
`else
    check("madd_off_busy", {31'b0, bus.busy}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("madd_off_busy_late", {31'b0, bus.busy}, 32'd0);
    check("madd_off_hi", bus.HI, 32'd0);
    check("madd_off_lo", bus.LO, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire
